key_sched_ctrl: RTL

//  Iterative AES-128 key-schedule sequencer. Accepts a cipher key over a valid/ready handshake.

---
 rtl/key_sched_ctrl_if.sv | 33 +++
 rtl/key_sched_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl_if.sv
// Key-schedule controller bus: key load handshake, status flags and round-key read port.
// The zeroize signal exists only when KEY_SCHED_ZEROIZE_EN is defined.
interface key_sched_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [127:0]      key;
    logic              key_valid;
    logic              key_ready;
    logic              busy;
    logic              done;
    logic              keys_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [127:0]      rd_data;
`ifdef KEY_SCHED_ZEROIZE_EN
    logic              zeroize;
`endif

    modport master (
`ifdef KEY_SCHED_ZEROIZE_EN
        output zeroize,
`endif
        output key, key_valid, rd_addr,
        input  key_ready, busy, done, keys_valid, rd_data
    );

    modport slave (
`ifdef KEY_SCHED_ZEROIZE_EN
        input  zeroize,
`endif
        input  key, key_valid, rd_addr,
        output key_ready, busy, done, keys_valid, rd_data
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock through a single func_g, 11-entry
// round-key file with a registered read port. Optional clear port: KEY_SCHED_ZEROIZE_EN.

module func_g (
    input  logic [31:0] w,
    input  logic [3:0]  rc_idx,
    output logic [31:0] g
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254 via an addition chain) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] rot;

    assign rot = {w[23:0], w[31:24]};
    assign g   = {sbox(rot[31:24]) ^ rcon(rc_idx), sbox(rot[23:16]),
                  sbox(rot[15:8]), sbox(rot[7:0])};
endmodule

module key_sched_ctrl #(
    parameter int NR     = 10,
    parameter int ADDR_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    key_sched_ctrl_if.slave bus
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [3:0]        prev_idx;
    logic [127:0]      rk [NR+1];
    logic [127:0]      prev_rk;
    logic [127:0]      next_rk;
    logic [31:0]       g;
    logic [31:0]       nw0, nw1, nw2, nw3;
    logic [ADDR_W-1:0] rd_idx;
    logic [127:0]      rd_next;

    // Word w0 occupies [127:96]; the key's first transmitted bit is bit 127 here.
    assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    assign prev_rk  = rk[prev_idx];

    func_g u_func_g (
        .w      (prev_rk[31:0]),
        .rc_idx (cnt),
        .g      (g)
    );

    assign nw0     = prev_rk[127:96] ^ g;
    assign nw1     = prev_rk[95:64]  ^ nw0;
    assign nw2     = prev_rk[63:32]  ^ nw1;
    assign nw3     = prev_rk[31:0]   ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.key_ready  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.keys_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            bus.done <= 1'b0;
`ifdef KEY_SCHED_ZEROIZE_EN
            if (bus.zeroize) begin
                state          <= IDLE;
                cnt            <= 4'd0;
                bus.key_ready  <= 1'b1;
                bus.busy       <= 1'b0;
                bus.keys_valid <= 1'b0;
                for (int i = 0; i <= NR; i++) rk[i] <= '0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (bus.key_valid && bus.key_ready) begin
                            rk[0]          <= bus.key;
                            cnt            <= 4'd1;
                            state          <= EXPAND;
                            bus.key_ready  <= 1'b0;
                            bus.busy       <= 1'b1;
                            bus.keys_valid <= 1'b0;
                        end else begin
                            // also raises key_ready on the first clock after reset
                            bus.key_ready <= 1'b1;
                        end
                    end
                    EXPAND: begin
                        rk[cnt] <= next_rk;
                        if (cnt == 4'(NR)) begin
                            state          <= IDLE;
                            bus.key_ready  <= 1'b1;
                            bus.busy       <= 1'b0;
                            bus.done       <= 1'b1;
                            bus.keys_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rd_idx = bus.rd_addr;

    always_comb begin
        rd_next = '0;
        if (rd_idx <= ADDR_W'(NR)) rd_next = rk[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else begin
`ifdef KEY_SCHED_ZEROIZE_EN
            if (bus.zeroize) bus.rd_data <= '0;
            else
`endif
            bus.rd_data <= rd_next;
        end
    end
endmodule
